pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/mips_defs.sv | 17 +
 rtl/pc_fetch_if.sv | 37 +++
 rtl/pc_fetch_adder.sv | 10 +
 rtl/pc_fetch.sv | 131 +++++++++++++
 tb/tb_pc_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared MIPS front-end definitions: reset vector, PC step and fetch FSM encoding.
package mips_defs;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2
   } fetch_state_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage signal bundle: redirect inputs, instruction bus and decode handoff.
interface pc_fetch_if;

   logic        br_taken;
   logic [31:0] br_target;
   logic        flush;
   logic [31:0] flush_pc;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adel;

   modport master (
      input  br_taken, br_target, flush, flush_pc,
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output if_valid, if_pc, if_inst, if_adel,
      input  if_ready
   );

   modport slave (
      output br_taken, br_target, flush, flush_pc,
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  if_valid, if_pc, if_inst, if_adel,
      output if_ready
   );

endinterface

// File: rtl/pc_fetch_adder.sv
// 32-bit adder used for the sequential PC increment.
module pc_fetch_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: single-outstanding bus requester with a one-entry output buffer.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   FS_REQ  | request pending for pc (or misaligned pc about to be flagged)
//   FS_WAIT | one request accepted, waiting for data_ok
//   FS_HOLD | fetched word buffered on if_*, waiting for if_ready
module pc_fetch
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   pc_fetch_if.master bus
);

   fetch_state_t state, state_d;
   logic [31:0]  pc, pc_d, pc_plus4;
   logic [31:0]  fetch_pc, fetch_pc_d;
   logic         cancel, cancel_d;
   logic         started;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_inst_q, if_inst_d;
   logic         if_adel_q, if_adel_d;
   logic         req;
   logic         redirect;
   logic [31:0]  redirect_pc;

   pc_fetch_adder u_pc_adder (
      .a   (pc),
      .b   (PC_STEP),
      .sum (pc_plus4)
   );

   assign redirect    = bus.flush | bus.br_taken;
   assign redirect_pc = bus.flush ? bus.flush_pc : bus.br_target;

   always_comb begin
      state_d    = state;
      pc_d       = pc;
      fetch_pc_d = fetch_pc;
      cancel_d   = cancel;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_adel_d  = if_adel_q;
      req        = 1'b0;
      case (state)
         FS_REQ: begin
            // started keeps inst_req low while reset is held and for the release cycle
            if (started) begin
               if (misaligned(pc)) begin
                  if (!redirect) begin
                     if_valid_d = 1'b1;
                     if_pc_d    = pc;
                     if_inst_d  = 32'd0;
                     if_adel_d  = 1'b1;
                     state_d    = FS_HOLD;
                  end
               end else begin
                  req = 1'b1;
                  if (bus.inst_addr_ok) begin
                     fetch_pc_d = pc;
                     pc_d       = pc_plus4;
                     cancel_d   = redirect;
                     state_d    = FS_WAIT;
                  end
               end
            end
         end
         FS_WAIT: begin
            if (bus.inst_data_ok) begin
               cancel_d = 1'b0;
               if (cancel || redirect) begin
                  state_d = FS_REQ;
               end else begin
                  if_valid_d = 1'b1;
                  if_pc_d    = fetch_pc;
                  if_inst_d  = bus.inst_rdata;
                  if_adel_d  = 1'b0;
                  state_d    = FS_HOLD;
               end
            end else if (redirect) begin
               cancel_d = 1'b1;
            end
         end
         FS_HOLD: begin
            if (redirect || bus.if_ready) begin
               if_valid_d = 1'b0;
               state_d    = FS_REQ;
            end
         end
         default: state_d = FS_REQ;
      endcase
      if (redirect) pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= FS_REQ;
         pc         <= RESET_PC;
         fetch_pc   <= 32'd0;
         cancel     <= 1'b0;
         started    <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'd0;
         if_inst_q  <= 32'd0;
         if_adel_q  <= 1'b0;
      end else begin
         state      <= state_d;
         pc         <= pc_d;
         fetch_pc   <= fetch_pc_d;
         cancel     <= cancel_d;
         started    <= 1'b1;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_adel_q  <= if_adel_d;
      end
   end

   assign bus.inst_req  = req;
   assign bus.inst_addr = pc;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.if_adel   = if_adel_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: bus responder, instruction-stream model and directed scenarios.
module tb_pc_fetch;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pc_fetch_if bus();

   pc_fetch #(.RESET_PC(RST_PC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // instruction memory contents as a pure function of the address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // ---------------- bus responder: zero-wait addr_ok, one-cycle data_ok when enabled
   bit          addr_en = 1'b1;
   bit          data_en = 1'b1;
   bit          stray   = 1'b0;
   bit          pending = 1'b0;
   bit          acc_last = 1'b0;
   logic [31:0] paddr, acc_addr;
   logic [31:0] acc_q[$];

   always @(negedge clk) begin
      if (!resetn) begin
         pending = 1'b0;
         acc_last = 1'b0;
         bus.inst_addr_ok = 1'b0;
         bus.inst_data_ok = 1'b0;
      end else begin
         if (acc_last) begin
            pending = 1'b1;
            paddr = acc_addr;
         end
         acc_last = 1'b0;
         bus.inst_data_ok = (pending && data_en) || stray;
         bus.inst_rdata = (pending && data_en) ? mem(paddr) : 32'hDEAD_BEEF;
         if (pending && data_en) pending = 1'b0;
         bus.inst_addr_ok = bus.inst_req && addr_en;
         if (bus.inst_req && addr_en) begin
            acc_last = 1'b1;
            acc_addr = bus.inst_addr;
            acc_q.push_back(bus.inst_addr);
         end
      end
   end

   // ---------------- model: the stream decode must see, checked every cycle
   logic [31:0] exp_pc = RST_PC;
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          lat_en = 1'b0;
   bit          prev_valid = 1'b0;
   logic [31:0] dlv_pc[$];
   logic [31:0] dlv_inst[$];

   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (!resetn) begin
         exp_pc = RST_PC;
         chk("model_reset_outputs",
             {bus.if_pc | bus.if_inst, 29'd0, bus.inst_req, bus.if_valid, bus.if_adel}, 32'd0);
         prev_valid = 1'b0;
      end else begin
         if (bus.if_valid) begin
            chk("model_if_pc", bus.if_pc, exp_pc);
            chk("model_if_inst", bus.if_inst, (exp_pc[1:0] != 2'b00) ? 32'd0 : mem(exp_pc));
            chk("model_if_adel", {31'd0, bus.if_adel}, {31'd0, exp_pc[1:0] != 2'b00});
            chk("model_no_req_while_valid", {31'd0, bus.inst_req}, 32'd0);
         end
         if (bus.inst_req)
            chk("model_req_addr", bus.inst_addr, (exp_pc[1:0] == 2'b00) ? exp_pc : 32'hxxxx_xxxx);
         if (bus.inst_req && bus.inst_addr_ok) acc_cyc = cyc;
         if (lat_en && bus.if_valid && !prev_valid && !bus.if_adel)
            chk("latency", cyc - acc_cyc, 32'd2);
         prev_valid = bus.if_valid;
         if (bus.flush) exp_pc = bus.flush_pc;
         else if (bus.br_taken) exp_pc = bus.br_target;
         else if (bus.if_valid && bus.if_ready) begin
            dlv_pc.push_back(bus.if_pc);
            dlv_inst.push_back(bus.if_inst);
            exp_pc = exp_pc + 32'd4;
         end
      end
   end

   // ---------------- directed scenarios
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input int max, input string name);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if (bus.if_valid) break;
      end
      chk(name, {31'd0, bus.if_valid}, 32'd1);
   endtask

   task automatic redirect_br(input logic [31:0] tgt);
      @(negedge clk);
      bus.br_taken = 1'b1;
      bus.br_target = tgt;
      @(negedge clk);
      bus.br_taken = 1'b0;
   endtask

   logic [31:0] t1_addr [3];
   logic [31:0] t1_inst [3];
   logic [23:0] pat_rdy  = 24'b1011_0010_1110_0101_1100_1011;
   logic [23:0] pat_addr = 24'b1110_1101_1011_1111_0111_1101;
   logic [23:0] pat_data = 24'b1101_1111_0110_1011_1110_1111;
   int          bad;

   initial begin
      t1_addr = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
      t1_inst = '{32'h1357_241F, 32'h1353_241F, 32'h135F_241F};
      bus.br_taken = 1'b0;
      bus.br_target = 32'd0;
      bus.flush = 1'b0;
      bus.flush_pc = 32'd0;
      bus.if_ready = 1'b1;
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata = 32'd0;

      step(3);
      #1;
      chk("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'd0);

      // sequential fetch after reset release
      @(negedge clk);
      resetn = 1'b1;
      lat_en = 1'b1;
      dlv_pc.delete();
      dlv_inst.delete();
      acc_q.delete();
      @(negedge clk);
      #1;
      chk("first_req", {31'd0, bus.inst_req}, 32'd1);
      chk("first_addr", bus.inst_addr, 32'hBFC0_0000);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (dlv_pc.size() >= 3) break;
      end
      lat_en = 1'b0;
      chk("t1_deliveries", dlv_pc.size() >= 3, 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("t1_bus_addr", (acc_q.size() > k) ? acc_q[k] : 32'hxxxx_xxxx, t1_addr[k]);
         chk("t1_if_pc", (dlv_pc.size() > k) ? dlv_pc[k] : 32'hxxxx_xxxx, t1_addr[k]);
         chk("t1_if_inst", (dlv_inst.size() > k) ? dlv_inst[k] : 32'hxxxx_xxxx, t1_inst[k]);
      end

      // decode stall: output held, no new request
      @(negedge clk);
      bus.br_taken = 1'b1;
      bus.br_target = 32'h8000_0100;
      bus.if_ready = 1'b0;
      @(negedge clk);
      bus.br_taken = 1'b0;
      wait_valid(10, "t2_valid_timeout");
      for (int k = 0; k < 5; k++) begin
         chk("t2_hold_valid", {31'd0, bus.if_valid}, 32'd1);
         chk("t2_hold_pc", bus.if_pc, 32'h8000_0100);
         chk("t2_hold_inst", bus.if_inst, 32'h1257_1BDF);
         chk("t2_hold_no_req", {31'd0, bus.inst_req}, 32'd0);
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      bus.if_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("t2_valid_fall", {31'd0, bus.if_valid}, 32'd0);
      chk("t2_next_addr", bus.inst_addr, 32'h8000_0104);

      // redirect parked in REQ, then redirect while WAITing on BFC00004
      @(negedge clk);
      addr_en = 1'b0;
      step(5);
      acc_q.delete();
      redirect_br(32'hBFC0_0004);
      data_en = 1'b0;
      addr_en = 1'b1;
      #1;
      chk("t3_req_redirect_addr", bus.inst_addr, 32'hBFC0_0004);
      chk("t3_req_redirect_req", {31'd0, bus.inst_req}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (acc_q.size() > 0) break;
         @(negedge clk);
         #1;
      end
      chk("t3_accepted", (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx, 32'hBFC0_0004);
      redirect_br(32'h8000_1000);
      data_en = 1'b1;
      wait_valid(15, "t3_valid_timeout");
      chk("t3_if_pc", bus.if_pc, 32'h8000_1000);
      chk("t3_if_inst", bus.if_inst, 32'h0357_1BDF);

      // flush beats branch
      @(negedge clk);
      addr_en = 1'b0;
      step(5);
      @(negedge clk);
      bus.flush = 1'b1;
      bus.flush_pc = 32'hBFC0_0380;
      bus.br_taken = 1'b1;
      bus.br_target = 32'h8000_2000;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.br_taken = 1'b0;
      #1;
      chk("t4_flush_addr", bus.inst_addr, 32'hBFC0_0380);
      @(negedge clk);
      addr_en = 1'b1;

      // misaligned target: address error, no bus request
      @(negedge clk);
      bus.br_taken = 1'b1;
      bus.br_target = 32'h8000_0002;
      bus.if_ready = 1'b0;
      acc_q.delete();
      @(negedge clk);
      bus.br_taken = 1'b0;
      wait_valid(10, "t5_valid_timeout");
      chk("t5_adel", {31'd0, bus.if_adel}, 32'd1);
      chk("t5_if_pc", bus.if_pc, 32'h8000_0002);
      chk("t5_if_inst", bus.if_inst, 32'd0);
      bad = 0;
      foreach (acc_q[k]) if (acc_q[k] == 32'h8000_0002) bad++;
      chk("t5_no_bus_req", bad, 32'd0);

      // redirect in HOLD with if_ready=1, then wrap at top of address space
      @(negedge clk);
      bus.br_taken = 1'b1;
      bus.br_target = 32'hFFFF_FFFC;
      bus.if_ready = 1'b1;
      @(negedge clk);
      bus.br_taken = 1'b0;
      bus.if_ready = 1'b0;
      #1;
      chk("t6_hold_redirect_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("t6_top_addr", bus.inst_addr, 32'hFFFF_FFFC);
      wait_valid(10, "t6_valid_timeout");
      chk("t6_top_inst", bus.if_inst, 32'hECAB_6420);
      @(negedge clk);
      bus.if_ready = 1'b1;
      data_en = 1'b0;
      @(negedge clk);
      #1;
      chk("t6_wrap_addr", bus.inst_addr, 32'h0000_0000);
      chk("t6_wrap_req", {31'd0, bus.inst_req}, 32'd1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("t6_rst_req", {31'd0, bus.inst_req}, 32'd0);
      chk("t6_rst_pc", bus.if_pc, 32'd0);
      step(2);
      @(negedge clk);
      resetn = 1'b1;
      data_en = 1'b1;
      @(negedge clk);
      #1;
      chk("t6_after_rst_addr", bus.inst_addr, 32'hBFC0_0000);

      // data_ok outside WAIT is ignored
      step(4);
      @(negedge clk);
      addr_en = 1'b0;
      step(5);
      @(negedge clk);
      stray = 1'b1;
      step(2);
      @(negedge clk);
      stray = 1'b0;
      #1;
      chk("t7_stray_ignored", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk);
      addr_en = 1'b1;

      // mixed stall/backpressure pattern with redirects, checked by the model
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         bus.if_ready = pat_rdy[k];
         addr_en = pat_addr[k];
         data_en = pat_data[k];
         bus.br_taken = (k == 9) || (k == 17);
         bus.br_target = 32'h8000_3000;
         bus.flush = (k == 17);
         bus.flush_pc = 32'h8000_4000;
      end
      @(negedge clk);
      bus.br_taken = 1'b0;
      bus.flush = 1'b0;
      bus.if_ready = 1'b1;
      addr_en = 1'b1;
      data_en = 1'b1;
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
